// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and default timing constants for the pipeline control unit.
package pipeline_control_pkg;

    localparam int DefMemTimeout  = 64;
    localparam int DefDrainCycles = 3;

    typedef enum logic [1:0] {
        Run,
        MemWait,
        Drain,
        Redirect
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PcSeq    = 2'b00,
        PcBranch = 2'b01,
        PcTrap   = 2'b10,
        PcMepc   = 2'b11
    } pc_src_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t StageRun = '{en: 1'b1, flush: 1'b0};

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Status bits from the pipeline stages and the control lines back to the
// pipeline registers and PC.
interface pipeline_control_unit_if;
    import pipeline_control_pkg::*;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        mem_trap;
    logic        mem_mret;
    logic        irq_pending;
    logic        imem_ack;
    // dmem_req stays high while a MEM access is outstanding; the cycle with
    // dmem_req && dmem_ack completes it, and data is usable in that cycle.
    logic        dmem_req;
    logic        dmem_ack;

    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        pc_en;
    pc_src_t     pc_src;
    logic        trap_taken;
    logic        bus_fault;
    logic        busy;
    ctrl_state_t state;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_trap, mem_mret, irq_pending, imem_ack,
               dmem_req, dmem_ack,
        output if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_en, pc_src, trap_taken, bus_fault, busy, state
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_trap, mem_mret, irq_pending, imem_ack,
               dmem_req, dmem_ack,
        input  if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_en, pc_src, trap_taken, bus_fault, busy, state
    );

endinterface

// File: rtl/pipeline_control_unit_hazard_detector.sv
// Load-use detection: a load in EX whose rd is read by the instruction in ID.
module hazard_detector (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    // x0 never carries a dependency, so a load to x0 cannot cause a stall.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: per-stage enable/flush, PC enable/select, trap entry,
// data-memory wait handling and interrupt drain.
module pipeline_control_unit
    import pipeline_control_pkg::*;
#(
    parameter int MemTimeout  = DefMemTimeout,
    parameter int DrainCycles = DefDrainCycles
) (
    input  logic                    clock,
    input  logic                    reset,
    pipeline_control_unit_if.master bus
);

    localparam int              CntW       = $clog2(MemTimeout);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(MemTimeout - 1);
    localparam logic [CntW-1:0] DrainInit  = CntW'(DrainCycles - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    ctrl_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    stage_ctrl_t if_id, id_ex, ex_mem, mem_wb;
    logic        pc_en, trap_taken, bus_fault;
    pc_src_t     pc_src;
    logic        load_use, dmem_stall;
    logic        advance, freeze, trap;

    hazard_detector u_hazard (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    assign dmem_stall = bus.dmem_req && !bus.dmem_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= Run;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        if_id      = StageRun;
        id_ex      = StageRun;
        ex_mem     = StageRun;
        mem_wb     = StageRun;
        pc_en      = 1'b1;
        pc_src     = PcSeq;
        trap_taken = 1'b0;
        bus_fault  = 1'b0;
        advance    = 1'b0;
        freeze     = 1'b0;
        trap       = 1'b0;

        case (state_q)
            Run: begin
                if (bus.mem_trap) begin
                    trap = 1'b1;
                end else if (bus.irq_pending && !bus.dmem_req) begin
                    state_d     = Drain;
                    cnt_d       = DrainInit;
                    pc_en       = 1'b0;
                    if_id.flush = 1'b1;
                end else if (bus.mem_mret) begin
                    pc_src       = PcMepc;
                    if_id.flush  = 1'b1;
                    id_ex.flush  = 1'b1;
                    ex_mem.flush = 1'b1;
                end else if (dmem_stall) begin
                    freeze  = 1'b1;
                    state_d = MemWait;
                    cnt_d   = CntOne;
                end else begin
                    advance = 1'b1;
                end
            end
            MemWait: begin
                if (bus.dmem_ack || !bus.dmem_req) begin
                    advance = 1'b1;
                    state_d = Run;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutCnt) begin
                    trap      = 1'b1;
                    bus_fault = 1'b1;
                    state_d   = Run;
                    cnt_d     = '0;
                end else begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q + CntOne;
                end
            end
            Drain: begin
                if (bus.mem_trap) begin
                    trap    = 1'b1;
                    state_d = Run;
                    cnt_d   = '0;
                end else if (dmem_stall) begin
                    freeze = 1'b1;
                end else begin
                    // Fetch is held off; older instructions retire, branches in EX are dropped.
                    pc_en       = 1'b0;
                    if_id.flush = 1'b1;
                    if (cnt_q == '0) state_d = Redirect;
                    else             cnt_d   = cnt_q - CntOne;
                end
            end
            Redirect: begin
                pc_src       = PcTrap;
                trap_taken   = 1'b1;
                if_id.flush  = 1'b1;
                id_ex.flush  = 1'b1;
                ex_mem.flush = 1'b1;
                state_d      = Run;
                cnt_d        = '0;
            end
            default: begin
                state_d = Run;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            if (bus.ex_branch_taken) begin
                pc_src      = PcBranch;
                if_id.flush = 1'b1;
                id_ex.flush = 1'b1;
            end else begin
                if (load_use) begin
                    pc_en       = 1'b0;
                    if_id.en    = 1'b0;
                    id_ex.flush = 1'b1;
                end
                if (!bus.imem_ack) begin
                    pc_en       = 1'b0;
                    if_id.flush = 1'b1;
                end
            end
        end

        if (freeze) begin
            if_id.en     = 1'b0;
            id_ex.en     = 1'b0;
            ex_mem.en    = 1'b0;
            mem_wb.en    = 1'b0;
            mem_wb.flush = 1'b1;
            pc_en        = 1'b0;
        end

        // The faulting instruction is squashed in MEM/WB so it never writes back.
        if (trap) begin
            pc_src       = PcTrap;
            pc_en        = 1'b1;
            trap_taken   = 1'b1;
            if_id.flush  = 1'b1;
            id_ex.flush  = 1'b1;
            ex_mem.flush = 1'b1;
            mem_wb.flush = 1'b1;
        end

        if (reset) begin
            if_id      = '{en: 1'b0, flush: 1'b1};
            id_ex      = '{en: 1'b0, flush: 1'b1};
            ex_mem     = '{en: 1'b0, flush: 1'b1};
            mem_wb     = '{en: 1'b0, flush: 1'b1};
            pc_en      = 1'b0;
            pc_src     = PcSeq;
            trap_taken = 1'b0;
            bus_fault  = 1'b0;
        end
    end

    assign bus.if_id_en     = if_id.en;
    assign bus.id_ex_en     = id_ex.en;
    assign bus.ex_mem_en    = ex_mem.en;
    assign bus.mem_wb_en    = mem_wb.en;
    assign bus.if_id_flush  = if_id.flush;
    assign bus.id_ex_flush  = id_ex.flush;
    assign bus.ex_mem_flush = ex_mem.flush;
    assign bus.mem_wb_flush = mem_wb.flush;
    assign bus.pc_en        = pc_en;
    assign bus.pc_src       = pc_src;
    assign bus.trap_taken   = trap_taken;
    assign bus.bus_fault    = bus_fault;
    assign bus.busy         = !reset && (state_q != Run);
    assign bus.state        = state_q;

endmodule
